// File: rtl/iob_sw_ctrl.sv
// Transfer sequencer for the tcache I/O switch: owns the precision/route selects,
// gates the source paths and counts sink beats. Define IOB_SW_CTRL_TIMEOUT_EN for the RUN watchdog.
module iob_sw_ctrl #(
  parameter int LEN_W     = 16,
  parameter int TIMEOUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_pric,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             sw_abort,
  output logic             iob_pric,
  output logic             iob_l2c_in_cfg,
  output logic             cu_path_en,
  output logic             l2in_path_en,
  input  logic             mon_out_vld,
  input  logic             mon_out_rdy,
  input  logic             mon_tc_vld,
  input  logic             mon_tc_rdy,
  input  logic             mon_tc_last,
  output logic             busy,
  output logic             done,
  output logic [2:0]       err,
  output logic             err_stray
);

  // Command handshake: a command transfers on a cycle where cmd_vld & cmd_rdy;
  // cmd_rdy depends only on state, never on cmd_vld.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             iob_pric_q, iob_pric_d;
  logic             l2c_cfg_q, l2c_cfg_d;
  logic             cu_en_q, cu_en_d;
  logic             l2_en_q, l2_en_d;
  logic             done_q, done_d;
  logic             stray_q, stray_d;
  logic [2:0]       err_q, err_d;

  logic out_beat, tc_beat, sink_beat, in_run, at_len, wd_expired, abort_now;

  assign out_beat  = mon_out_vld & mon_out_rdy;
  assign tc_beat   = mon_tc_vld & mon_tc_rdy;
  assign sink_beat = (mode_q == 2'd0) ? out_beat : tc_beat;
  assign in_run    = (state_q == S_RUN);
  assign at_len    = (cnt_q == len_q);

`ifdef IOB_SW_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (!in_run || sink_beat) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  // A beat arriving on the terminal count keeps the transfer alive.
  assign wd_expired = in_run & ~sink_beat & (&wd_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  assign abort_now = sw_abort | wd_expired;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    iob_pric_d = iob_pric_q;
    l2c_cfg_d  = l2c_cfg_q;
    err_d      = 3'b000;
    stray_d    = (out_beat | tc_beat) & ~in_run;

    case (state_q)
      S_IDLE: begin
        if (cmd_vld) begin
          if (cmd_mode == 2'd3) begin
            err_d[0] = 1'b1;
          end else begin
            mode_d     = cmd_mode;
            len_d      = cmd_len;
            // Selects change only on the accept edge so they are stable during SETUP.
            iob_pric_d = cmd_pric;
            l2c_cfg_d  = (cmd_mode == 2'd2);
            state_d    = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        cnt_d = '0;
        if (sw_abort) begin
          err_d[2] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (sink_beat && (mode_q != 2'd0) && (mon_tc_last != at_len)) begin
          err_d[1] = 1'b1;
        end
        if (abort_now) begin
          err_d[2] = 1'b1;
          state_d  = S_IDLE;
        end else if (sink_beat) begin
          if (at_len) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Enables and done are registered images of the next state.
    cu_en_d = (state_d == S_RUN) & (mode_d != 2'd1);
    l2_en_d = (state_d == S_RUN) & (mode_d != 2'd0);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'd0;
      len_q      <= '0;
      cnt_q      <= '0;
      iob_pric_q <= 1'b0;
      l2c_cfg_q  <= 1'b0;
      cu_en_q    <= 1'b0;
      l2_en_q    <= 1'b0;
      done_q     <= 1'b0;
      stray_q    <= 1'b0;
      err_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      iob_pric_q <= iob_pric_d;
      l2c_cfg_q  <= l2c_cfg_d;
      cu_en_q    <= cu_en_d;
      l2_en_q    <= l2_en_d;
      done_q     <= done_d;
      stray_q    <= stray_d;
      err_q      <= err_d;
    end
  end

  assign cmd_rdy        = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign iob_pric       = iob_pric_q;
  assign iob_l2c_in_cfg = l2c_cfg_q;
  assign cu_path_en     = cu_en_q;
  assign l2in_path_en   = l2_en_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_stray      = stray_q;

endmodule

// File: doc/iob_sw_ctrl.md
# iob_sw_ctrl

Transfer sequencer for the tcache I/O switch datapath. Accepts one transfer command at a time and drives the switch's precision (`iob_pric`) and routing (`iob_l2c_in_cfg`) selects. Changes the selects only between transfers, gates the source paths on and off, and counts completed beats at the sink. Signals completion or error to the issuing controller. It sits beside the switch in the tcache and is the only agent allowed to reconfigure it.

## Interface
Parameters:
- `LEN_W`, 16, width of the beat-count field; a transfer carries 1..2^LEN_W beats.
- `TIMEOUT_W`, 12, width of the watchdog counter; used only with `IOB_SW_CTRL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_vld`  in  1  command valid
- `cmd_rdy`  out  1  command ready; high only in IDLE
- `cmd_mode`  in  2  0: CU→L2 out; 1: L2 in→tcache; 2: CU→tcache loopback; 3: reserved
- `cmd_pric`  in  1  1: int16, 0: int8
- `cmd_len`  in  LEN_W  beats minus one
- `sw_abort`  in  1  synchronous abort request
- `iob_pric`  out  1  precision select to the switch
- `iob_l2c_in_cfg`  out  1  route select to the switch; 1 only in mode 2
- `cu_path_en`  out  1  integration ANDs this into the CU bank ready and valid
- `l2in_path_en`  out  1  integration ANDs this into the L2-in valid and ready
- `mon_out_vld`, `mon_out_rdy`  in  1 each  L2-out handshake monitor
- `mon_tc_vld`, `mon_tc_rdy`, `mon_tc_last`  in  1 each  tcache-sink handshake monitor
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse on normal completion
- `err`  out  3  one-cycle pulses: [0] bad mode, [1] last mismatch, [2] abort or timeout
- `err_stray`  out  1  one-cycle pulse on a sink beat seen outside RUN

## Operation
**States:** IDLE, SETUP, RUN, DONE.

**IDLE**
- `cmd_rdy` = 1.
- On `cmd_vld`, latch mode, pric and len.
- Mode 3: pulse `err[0]` next cycle and stay in IDLE; the selects are unchanged.
- Any other mode: go to SETUP.

**SETUP** (exactly 1 cycle)
- `iob_pric` and `iob_l2c_in_cfg` load from the latched command. They are registered and are written nowhere else.
- Both path enables are 0.
- Beat counter clears to 0.
- Go to RUN.

**RUN**
- Path enables by mode: mode 0 `cu_path_en`=1; mode 1 `l2in_path_en`=1; mode 2 both = 1.
- Sink beat definition: mode 0 = `mon_out_vld & mon_out_rdy`; modes 1 and 2 = `mon_tc_vld & mon_tc_rdy`.
- Each sink beat increments the counter.
- When a beat arrives with counter == len: both enables drop the next cycle and the state goes to DONE.
- Last check (modes 1 and 2 only): `mon_tc_last` must be high exactly on the final beat. It is sampled on every beat; any mismatch pulses `err[1]` on the following cycle, and counting continues.

**DONE** (1 cycle)
- `done` pulses, then IDLE.

**Abort**
- `sw_abort` in SETUP or RUN: enables drop the next cycle, `err[2]` pulses, state goes to IDLE, no `done`.
- Abort takes priority over a simultaneous final beat.
- `sw_abort` in IDLE or DONE is ignored.

**Stray beats**
- A sink beat on either monitor while not in RUN pulses `err_stray`. It is not counted.
- In RUN, beats on the sink of the other mode are ignored.

**Counter**
- LEN_W bits, compared for equality against len, so it never wraps.
- len = 0 means a single beat.
- len = all-ones means 2^LEN_W beats.

## Timing
**Reset values:** state IDLE; `cmd_rdy` 1; `iob_pric` 0; `iob_l2c_in_cfg` 0; both enables 0; `busy` 0; `done` 0; `err` 0; `err_stray` 0.

**Latency**
- Command accept to first enable: 2 cycles. Accept in cycle T, SETUP in T+1, enables high in T+2.
- Final beat to `done`: 1 cycle.
- Earliest next accept: 2 cycles after the final beat.

**Enables**
- All enables are registered outputs.
- The datapath has pipeline stages (up to 2 registered stages) between the path enable and the sink monitor, so beats may still arrive for a few cycles after an abort. These report `err_stray`, as intended.

**Selects:** `iob_pric` and `iob_l2c_in_cfg` hold their value through RUN, DONE and IDLE until the next SETUP.

**Asynchronous reset mid-transfer:** everything returns to the reset values immediately, with no `done` and no `err`.

## Configuration
`IOB_SW_CTRL_TIMEOUT_EN`:
- Defined:
  - A TIMEOUT_W watchdog runs in RUN, clears on every sink beat, and clears on entry to RUN.
  - When it reaches all-ones it acts as an abort: `err[2]` pulses and the state goes to IDLE.
  - A beat in the same cycle as the terminal count wins.
- Undefined: no watchdog logic; RUN waits indefinitely.

## Test plan
- Mode 0, pric=1, len=3, `mon_out` ready every cycle. Required: selects 1/0 at T+1, `cu_path_en` high T+2..T+5, `done` at T+6, `err`=0.
- Mode 2, len=0, `mon_tc_last`=1 on the single beat. Required: `iob_l2c_in_cfg`=1 and both enables high, `done` 1 cycle after the beat. Repeat with `last`=0. Required: `err[1]` pulse and `done` still asserted.
- `cmd_mode`=3. Required: `err[0]` pulse, `cmd_rdy` stays 1, selects unchanged, `busy` stays 0.
- Mode 1, len=7, `sw_abort` after 4 beats, then 2 more tc beats. Required: `err[2]` pulse, no `done`, two `err_stray` pulses, enables 0.
- With `IOB_SW_CTRL_TIMEOUT_EN` and TIMEOUT_W=4: mode 1 with no beats. Required: `err[2]` pulse 15 cycles after RUN entry, then IDLE. A beat on cycle 15 instead resets the watchdog.
- `rst_n` low mid-RUN (len=10, 5 beats done). Required: all outputs at their reset values immediately, and the next command completes normally with 11 beats.
